// File: rtl/stage_mem.sv
// Memory stage: forwards ALU results and runs byte/half/word loads and stores over a req/gnt/rvalid bus.
// Optional feature macro MEM_MISALIGN_TRAP_EN: flag misaligned half/word accesses instead of aligning them.
module stage_mem #(
  parameter int unsigned WD_SIZE        = 32,
  parameter int unsigned INSTR_REG_BITS = 5
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic                      instr_ld_i,
  input  logic                      instr_st_i,
  input  logic [2:0]                funct3_i,
  input  logic [WD_SIZE-1:0]        alu_result_i,
  input  logic [WD_SIZE-1:0]        rs2_data_i,
  input  logic [INSTR_REG_BITS-1:0] rd_i,
  output logic                      mem_req_o,
  output logic                      mem_we_o,
  output logic [WD_SIZE-1:0]        mem_addr_o,
  output logic [WD_SIZE-1:0]        mem_wdata_o,
  output logic [3:0]                mem_be_o,
  input  logic                      mem_gnt_i,
  input  logic                      mem_rvalid_i,
  input  logic [WD_SIZE-1:0]        mem_rdata_i,
  output logic                      valid_o,
  output logic [INSTR_REG_BITS-1:0] rd_o,
  output logic [WD_SIZE-1:0]        wb_data_o,
  output logic                      wb_en_o
`ifdef MEM_MISALIGN_TRAP_EN
  ,
  output logic                      misalign_o
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R} state_e;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  state_e                    state_q;
  logic [1:0]                size_q;
  logic [1:0]                off_q;
  logic                      sgn_q;
  logic                      st_q;
  logic [INSTR_REG_BITS-1:0] rd_q;

  logic [1:0]         size_c;
  logic [1:0]         off_c;
  logic [3:0]         base_c;
  logic [3:0]         be_c;
  logic [WD_SIZE-1:0] wdata_c;
  logic [WD_SIZE-1:0] lane_c;
  logic [WD_SIZE-1:0] ld_data_c;
`ifdef MEM_MISALIGN_TRAP_EN
  logic               mis_c;
`endif

  assign ready_o = (state_q == IDLE);

  // Access size, aligned lane offset, byte enables and replicated store data for the incoming op.
  always_comb begin
    size_c = SZ_WORD;
    if (funct3_i == 3'b000 || (instr_ld_i && funct3_i == 3'b100)) begin
      size_c = SZ_BYTE;
    end else if (funct3_i == 3'b001 || (instr_ld_i && funct3_i == 3'b101)) begin
      size_c = SZ_HALF;
    end
    case (size_c)
      SZ_BYTE: begin
        off_c   = alu_result_i[1:0];
        base_c  = 4'b0001;
        wdata_c = {4{rs2_data_i[7:0]}};
      end
      SZ_HALF: begin
        off_c   = {alu_result_i[1], 1'b0};
        base_c  = 4'b0011;
        wdata_c = {2{rs2_data_i[15:0]}};
      end
      default: begin
        off_c   = 2'b00;
        base_c  = 4'b1111;
        wdata_c = rs2_data_i;
      end
    endcase
    be_c = 4'(base_c << off_c);
`ifdef MEM_MISALIGN_TRAP_EN
    mis_c = (size_c == SZ_HALF && alu_result_i[0]) ||
            (size_c == SZ_WORD && alu_result_i[1:0] != 2'b00);
`endif
  end

  // Load lane extraction with sign or zero extension.
  always_comb begin
    lane_c = mem_rdata_i >> {off_q, 3'b000};
    case (size_q)
      SZ_BYTE: ld_data_c = {{24{sgn_q & lane_c[7]}}, lane_c[7:0]};
      SZ_HALF: ld_data_c = {{16{sgn_q & lane_c[15]}}, lane_c[15:0]};
      default: ld_data_c = lane_c;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      size_q      <= SZ_WORD;
      off_q       <= 2'b00;
      sgn_q       <= 1'b0;
      st_q        <= 1'b0;
      rd_q        <= '0;
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
      mem_be_o    <= 4'b0000;
      valid_o     <= 1'b0;
      rd_o        <= '0;
      wb_data_o   <= '0;
      wb_en_o     <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_o  <= 1'b0;
`endif
    end else begin
      valid_o <= 1'b0;
      wb_en_o <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
      misalign_o <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            rd_q <= rd_i;
            if (!(instr_ld_i || instr_st_i)) begin
              valid_o   <= 1'b1;
              wb_en_o   <= (rd_i != '0);
              wb_data_o <= alu_result_i;
              rd_o      <= rd_i;
`ifdef MEM_MISALIGN_TRAP_EN
            end else if (mis_c) begin
              valid_o    <= 1'b1;
              misalign_o <= 1'b1;
              rd_o       <= rd_i;
`endif
            end else begin
              size_q      <= size_c;
              off_q       <= off_c;
              sgn_q       <= ~funct3_i[2];
              st_q        <= instr_st_i;
              mem_req_o   <= 1'b1;
              mem_we_o    <= instr_st_i;
              mem_addr_o  <= {alu_result_i[WD_SIZE-1:2], 2'b00};
              mem_wdata_o <= wdata_c;
              mem_be_o    <= be_c;
              state_q     <= REQ;
            end
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            mem_req_o <= 1'b0;
            mem_we_o  <= 1'b0;
            if (st_q) begin
              valid_o <= 1'b1;
              rd_o    <= rd_q;
              state_q <= IDLE;
            end else begin
              state_q <= WAIT_R;
            end
          end
        end
        WAIT_R: begin
          if (mem_rvalid_i) begin
            valid_o   <= 1'b1;
            wb_en_o   <= (rd_q != '0);
            wb_data_o <= ld_data_c;
            rd_o      <= rd_q;
            state_q   <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
